// File: rtl/timer_pkg.sv
// timer_pkg: shared types and helpers for the millisecond timer scheduler.
// Holds the channel state encoding, default clock/tick rates and the
// prescaler divisor helpers used at elaboration time.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } ch_state_e;

   localparam int unsigned DEF_CLK_HZ  = 100_000_000;
   localparam int unsigned DEF_TICK_HZ = 1000;

   // Clock cycles per tick; 0 flags an unusable tick rate.
   function automatic int unsigned div_of(input int unsigned clk_hz,
                                          input int unsigned tick_hz);
      return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
   endfunction

   // True when the tick rate divides the clock exactly with at least two cycles per tick.
   function automatic bit div_ok(input int unsigned clk_hz,
                                 input int unsigned tick_hz);
      return (tick_hz != 0) && ((clk_hz / tick_hz) >= 2) && ((clk_hz % tick_hz) == 0);
   endfunction

endpackage

// File: rtl/ms_timer_scheduler_tick_gen.sv
// tick_gen: free-running prescaler over 0..DIV-1. The tick output is high
// for exactly one cycle, the cycle in which the count sits at DIV-1.
module tick_gen #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] cnt_q;
   logic [PW-1:0] cnt_d;

   // Advance the count, wrapping to zero on the tick cycle.
   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/ms_timer_scheduler.sv
// ms_timer_scheduler: CH countdown timers sharing one prescaled tick, with
// expiry events delivered one per cycle over a valid/ready port chosen by a
// round-robin arbiter. Optional feature macro: TIMER_SCHED_PERIODIC_EN
// (auto-reload on expiry and sticky per-channel overrun flags).
module ms_timer_scheduler
   import timer_pkg::*;
#(
   parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
   parameter int unsigned TICK_HZ = DEF_TICK_HZ,
   parameter int unsigned CH      = 4,
   parameter int unsigned CW      = 16,
   localparam int unsigned CHW    = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CH-1:0]    start,
   input  logic [CH*CW-1:0] load_ticks,
   input  logic [CH-1:0]    cancel,
   output logic [CH-1:0]    busy,
   output logic             tick,
   output logic             exp_valid,
   output logic [CHW-1:0]   exp_ch,
   input  logic             exp_ready
`ifdef TIMER_SCHED_PERIODIC_EN
   ,
   output logic [CH-1:0]    overrun
`endif
);

   localparam int unsigned DIV = div_of(CLK_HZ, TICK_HZ);

   if (!div_ok(CLK_HZ, TICK_HZ)) begin : g_bad_div
      $error("ms_timer_scheduler: CLK_HZ/TICK_HZ must be an exact integer >= 2");
   end
   if ((CH < 1) || (CH > 16)) begin : g_bad_ch
      $error("ms_timer_scheduler: CH must be in 1..16");
   end

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   ch_state_e      state_q [CH];
   ch_state_e      state_d [CH];
   logic [CW-1:0]  cnt_q   [CH];
   logic [CW-1:0]  cnt_d   [CH];
   logic [CW-1:0]  ld_w    [CH];

   logic [CH-1:0]  req;
   logic [CH-1:0]  gnt;
   logic           gnt_vld;
   logic [CHW-1:0] gnt_idx;
   logic           slot_free;

   logic           exp_valid_q, exp_valid_d;
   logic [CHW-1:0] exp_ch_q, exp_ch_d;
   logic [CHW-1:0] ptr_q, ptr_d;

`ifdef TIMER_SCHED_PERIODIC_EN
   // evt_q marks an ungranted event of a channel that keeps running.
   logic [CH-1:0]  evt_q, evt_d;
   logic [CH-1:0]  ovr_q, ovr_d;
   logic [CW-1:0]  rld_q [CH];
   logic [CW-1:0]  rld_d [CH];
`endif

   for (genvar g = 0; g < CH; g++) begin : g_ch
      assign ld_w[g] = load_ticks[g*CW +: CW];
      assign busy[g] = (state_q[g] != IDLE);
   end

   // The slot can take a new event when empty or when being drained this cycle.
   assign slot_free = !exp_valid_q || exp_ready;

   // Arbitration candidates: pending events not displaced by cancel or start this cycle.
   always_comb begin
      req = '0;
      for (int i = 0; i < CH; i++) begin
`ifdef TIMER_SCHED_PERIODIC_EN
         req[i] = ((state_q[i] == PEND) || evt_q[i]) && !start[i] && !cancel[i];
`else
         req[i] = (state_q[i] == PEND) && !start[i] && !cancel[i];
`endif
      end
   end

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      int unsigned j;
      logic        found;
      j       = 0;
      found   = 1'b0;
      gnt_idx = '0;
      for (int unsigned k = 1; k <= CH; k++) begin
         j = (32'(ptr_q) + k) % CH;
         if (!found && req[CHW'(j)]) begin
            found   = 1'b1;
            gnt_idx = CHW'(j);
         end
      end
      gnt_vld = found && slot_free;
      gnt     = '0;
      for (int i = 0; i < CH; i++) begin
         gnt[i] = gnt_vld && (gnt_idx == CHW'(i));
      end
   end

   // Per-channel next state: cancel beats start, start beats tick and grant.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         if (cancel[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
         end else if (start[i]) begin
            if (ld_w[i] != '0) begin
               state_d[i] = RUN;
               cnt_d[i]   = ld_w[i];
            end else begin
               state_d[i] = PEND;
               cnt_d[i]   = '0;
            end
         end else begin
            if (gnt[i] && (state_q[i] == PEND)) begin
               state_d[i] = IDLE;
            end
            if ((state_q[i] == RUN) && tick) begin
               if (cnt_q[i] == CW'(1)) begin
`ifdef TIMER_SCHED_PERIODIC_EN
                  cnt_d[i] = rld_q[i];
`else
                  state_d[i] = PEND;
                  cnt_d[i]   = '0;
`endif
               end else begin
                  cnt_d[i] = cnt_q[i] - CW'(1);
               end
            end
         end
      end
   end

`ifdef TIMER_SCHED_PERIODIC_EN
   // Reload value, queued-event flag and sticky overrun per channel.
   always_comb begin
      evt_d = evt_q;
      ovr_d = ovr_q;
      for (int i = 0; i < CH; i++) begin
         rld_d[i] = rld_q[i];
         if (cancel[i]) begin
            evt_d[i] = 1'b0;
            ovr_d[i] = 1'b0;
         end else if (start[i]) begin
            evt_d[i] = 1'b0;
            ovr_d[i] = 1'b0;
            rld_d[i] = ld_w[i];
         end else begin
            if (gnt[i]) begin
               evt_d[i] = 1'b0;
            end
            if ((state_q[i] == RUN) && tick && (cnt_q[i] == CW'(1))) begin
               if (evt_q[i] && !gnt[i]) begin
                  ovr_d[i] = 1'b1;
               end
               evt_d[i] = 1'b1;
            end
         end
      end
   end

   assign overrun = ovr_q;
`endif

   // Output slot: hold until accepted, refill from the arbiter on the same edge.
   always_comb begin
      exp_valid_d = exp_valid_q;
      exp_ch_d    = exp_ch_q;
      ptr_d       = ptr_q;
      if (exp_valid_q && exp_ready) begin
         exp_valid_d = 1'b0;
      end
      if (gnt_vld) begin
         exp_valid_d = 1'b1;
         exp_ch_d    = gnt_idx;
         ptr_d       = gnt_idx;
      end
   end

   // Channel state and countdown registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

`ifdef TIMER_SCHED_PERIODIC_EN
   // Periodic-mode bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_q <= '0;
         ovr_q <= '0;
         for (int i = 0; i < CH; i++) begin
            rld_q[i] <= '0;
         end
      end else begin
         evt_q <= evt_d;
         ovr_q <= ovr_d;
         for (int i = 0; i < CH; i++) begin
            rld_q[i] <= rld_d[i];
         end
      end
   end
`endif

   // Output slot and round-robin pointer; pointer starts at CH-1 so channel 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_valid_q <= 1'b0;
         exp_ch_q    <= '0;
         ptr_q       <= CHW'(CH - 1);
      end else begin
         exp_valid_q <= exp_valid_d;
         exp_ch_q    <= exp_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign exp_valid = exp_valid_q;
   assign exp_ch    = exp_ch_q;

endmodule

// File: tb/tb_ms_timer_scheduler.sv
// tb_ms_timer_scheduler: scoreboard bench for ms_timer_scheduler with
// DIV=10, CH=4, CW=8. Optional macro TIMER_SCHED_PERIODIC_EN adds the
// periodic/overrun scenario.
module tb_ms_timer_scheduler;

   localparam int CH  = 4;
   localparam int CW  = 8;
   localparam int DIV = 10;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [CH-1:0]    start;
   logic [CH*CW-1:0] load_ticks;
   logic [CH-1:0]    cancel;
   logic [CH-1:0]    busy;
   logic             tick;
   logic             exp_valid;
   logic [1:0]       exp_ch;
   logic             exp_ready;
`ifdef TIMER_SCHED_PERIODIC_EN
   logic [CH-1:0]    overrun;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   int tb_phase;

   ms_timer_scheduler #(
      .CLK_HZ  (1000),
      .TICK_HZ (100),
      .CH      (CH),
      .CW      (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .load_ticks (load_ticks),
      .cancel     (cancel),
      .busy       (busy),
      .tick       (tick),
      .exp_valid  (exp_valid),
      .exp_ch     (exp_ch),
      .exp_ready  (exp_ready)
`ifdef TIMER_SCHED_PERIODIC_EN
      ,
      .overrun    (overrun)
`endif
   );

   always #5 clk = ~clk;

   // Reference prescaler phase, counted from reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_phase <= 0;
      else        tb_phase <= (tb_phase == DIV - 1) ? 0 : tb_phase + 1;
   end

   // Monitor: tick phase every cycle, and scoreboard pop on each accepted event.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         n_checks++;
         if (tick !== (tb_phase == DIV - 1)) begin
            n_fail++;
            $display("FAIL tick_phase: tick=%b phase=%0d", tick, tb_phase);
         end
         if (exp_valid === 1'b1 && exp_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event: exp_ch=%0d, none expected", exp_ch);
            end else begin
               int e;
               e = exp_q.pop_front();
               if (exp_ch !== 2'(e)) begin
                  n_fail++;
                  $display("FAIL event_order: exp_ch=%0d expected %0d", exp_ch, e);
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start      = '0;
      cancel     = '0;
      load_ticks = '0;
      exp_ready  = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic set_start(input int ch, input logic [CW-1:0] ld);
      start[ch] = 1'b1;
      load_ticks[ch*CW +: CW] = ld;
   endtask

   task automatic quiesce();
      cancel = '1;
      step(1);
      cancel = '0;
   endtask

   task automatic wait_ticks(input int n, output bit ok);
      int seen;
      int cyc;
      seen = 0;
      cyc  = 0;
      while (seen < n && cyc < 15 * n) begin
         if (tick === 1'b1) seen++;
         step(1);
         cyc++;
      end
      ok = (seen == n);
   endtask

   task automatic test_reset();
      start = '0; cancel = '0; load_ticks = '0; exp_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (tick !== 1'b0 || exp_valid !== 1'b0 || exp_ch !== 2'd0 || busy !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_values: tick=%b exp_valid=%b exp_ch=%0d busy=%b, required 0 0 0 0000",
                  tick, exp_valid, exp_ch, busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         n_checks++;
         if (tick !== ((k % DIV) == DIV - 1)) begin
            n_fail++;
            $display("FAIL idle_tick: cycle %0d tick=%b required %b", k, tick, ((k % DIV) == DIV - 1));
         end
      end
      n_checks++;
      if (exp_valid !== 1'b0 || busy !== 4'd0) begin
         n_fail++;
         $display("FAIL idle_quiet: exp_valid=%b busy=%b, required 0 0000", exp_valid, busy);
      end
   endtask

   task automatic test_single();
      int p, d1, want, lat;
      do_reset();
      step(3);
      p = tb_phase;
      d1 = (p == DIV - 1) ? DIV : (DIV - 1 - p);
      want = d1 + 2 * DIV + 2;
      set_start(2, 8'd3);
      exp_q.push_back(2);
      step(1);
      start = '0;
      lat = 1;
      n_checks++;
      if (busy !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_busy: busy=%b required 0100", busy);
      end
      while (exp_valid !== 1'b1 && lat < 200) begin
         step(1);
         lat++;
      end
      n_checks++;
      if (lat != want) begin
         n_fail++;
         $display("FAIL single_latency: exp_valid after %0d cycles, required %0d", lat, want);
      end
      n_checks++;
      if (exp_ch !== 2'd2 || busy[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_event: exp_ch=%0d busy2=%b, required 2 0", exp_ch, busy[2]);
      end
      quiesce();
   endtask

   task automatic test_back_to_back();
      int order[3];
      int cyc;
      order = '{0, 1, 3};
      do_reset();
      exp_ready = 1'b0;
      set_start(0, 8'd2); set_start(1, 8'd2); set_start(3, 8'd2);
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
      step(1);
      start = '0;
      cyc = 0;
      while (exp_valid !== 1'b1 && cyc < 60) begin
         step(1);
         cyc++;
      end
      n_checks++;
      if (exp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_offer: exp_valid=%b required 1", exp_valid);
      end
      for (int k = 0; k < 5; k++) begin
         step(1);
         n_checks++;
         if (exp_valid !== 1'b1 || exp_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_hold: exp_valid=%b exp_ch=%0d, required 1 0", exp_valid, exp_ch);
         end
      end
      exp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (exp_valid !== 1'b1 || exp_ch !== 2'(order[k])) begin
            n_fail++;
            $display("FAIL b2b_stream: exp_valid=%b exp_ch=%0d, required 1 %0d", exp_valid, exp_ch, order[k]);
         end
         step(1);
      end
      n_checks++;
      if (exp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: exp_valid=%b required 0", exp_valid);
      end
      quiesce();
   endtask

   task automatic test_cancel();
      bit ok;
      bit seen;
      do_reset();
      set_start(1, 8'd5);
      step(1);
      start = '0;
      wait_ticks(2, ok);
      n_checks++;
      if (!ok || busy[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL cancel_run: ticks_ok=%b busy1=%b, required 1 1", ok, busy[1]);
      end
      cancel[1] = 1'b1;
      step(1);
      cancel = '0;
      n_checks++;
      if (busy[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel_busy: busy1=%b required 0", busy[1]);
      end
      seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (exp_valid === 1'b1) seen = 1'b1;
         step(1);
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel_noevent: event seen=%b required 0", seen);
      end
      set_start(1, 8'd5);
      cancel[1] = 1'b1;
      step(1);
      start = '0;
      cancel = '0;
      n_checks++;
      if (busy[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel_vs_start: busy1=%b required 0", busy[1]);
      end
      seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (exp_valid === 1'b1) seen = 1'b1;
         step(1);
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel_vs_start_noevent: event seen=%b required 0", seen);
      end
   endtask

   task automatic test_load_zero();
      do_reset();
      set_start(0, 8'd0);
      exp_q.push_back(0);
      step(1);
      start = '0;
      n_checks++;
      if (busy[0] !== 1'b1 || exp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_pend: busy0=%b exp_valid=%b, required 1 0", busy[0], exp_valid);
      end
      step(1);
      n_checks++;
      if (exp_valid !== 1'b1 || exp_ch !== 2'd0 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_offer: exp_valid=%b exp_ch=%0d busy0=%b, required 1 0 0", exp_valid, exp_ch, busy[0]);
      end
      step(1);
      n_checks++;
      if (exp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_drain: exp_valid=%b required 0", exp_valid);
      end
   endtask

   task automatic test_start_wins();
      int cyc;
      do_reset();
      set_start(0, 8'd0); set_start(1, 8'd0);
      step(1);
      start = '0;
      set_start(0, 8'd4);
      exp_q.push_back(1);
      exp_q.push_back(0);
      step(1);
      start = '0;
      n_checks++;
      if (exp_valid !== 1'b1 || exp_ch !== 2'd1 || busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL start_wins: exp_valid=%b exp_ch=%0d busy0=%b, required 1 1 1", exp_valid, exp_ch, busy[0]);
      end
      step(1);
      cyc = 0;
      while (!(exp_valid === 1'b1 && exp_ch === 2'd0) && cyc < 80) begin
         step(1);
         cyc++;
      end
      n_checks++;
      if (cyc >= 80) begin
         n_fail++;
         $display("FAIL restart_expiry: no event from channel 0 within %0d cycles", cyc);
      end
      step(1);
      quiesce();
      exp_ready = 1'b0;
      set_start(2, 8'd0);
      exp_q.push_back(2);
      step(1);
      start = '0;
      step(1);
      cancel[2] = 1'b1;
      step(1);
      cancel = '0;
      n_checks++;
      if (exp_valid !== 1'b1 || exp_ch !== 2'd2 || busy[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL committed_event: exp_valid=%b exp_ch=%0d busy2=%b, required 1 2 0", exp_valid, exp_ch, busy[2]);
      end
      exp_ready = 1'b1;
      step(1);
      n_checks++;
      if (exp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL committed_drain: exp_valid=%b required 0", exp_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      exp_ready = 1'b0;
      set_start(3, 8'd0);
      step(1);
      start = '0;
      set_start(1, 8'd7);
      step(1);
      start = '0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (exp_valid !== 1'b0 || busy !== 4'd0 || exp_ch !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid: exp_valid=%b busy=%b exp_ch=%0d, required 0 0000 0", exp_valid, busy, exp_ch);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_ready = 1'b1;
      step(2);
   endtask

`ifdef TIMER_SCHED_PERIODIC_EN
   task automatic test_periodic();
      bit ok;
      do_reset();
      exp_ready = 1'b0;
      set_start(3, 8'd1);
      exp_q.push_back(3);
      step(1);
      start = '0;
      wait_ticks(2, ok);
      n_checks++;
      if (!ok || overrun[3] !== 1'b0 || exp_valid !== 1'b1 || exp_ch !== 2'd3) begin
         n_fail++;
         $display("FAIL periodic_queue: ok=%b overrun3=%b exp_valid=%b exp_ch=%0d, required 1 0 1 3",
                  ok, overrun[3], exp_valid, exp_ch);
      end
      wait_ticks(1, ok);
      n_checks++;
      if (!ok || overrun[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL periodic_overrun: ok=%b overrun3=%b, required 1 1", ok, overrun[3]);
      end
      cancel[3] = 1'b1;
      step(1);
      cancel = '0;
      n_checks++;
      if (overrun[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL periodic_clear: overrun3=%b required 0", overrun[3]);
      end
      exp_ready = 1'b1;
      step(2);
      n_checks++;
      if (exp_valid !== 1'b0 || busy[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL periodic_drain: exp_valid=%b busy3=%b, required 0 0", exp_valid, busy[3]);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_cancel();
      test_load_zero();
      test_start_wins();
      test_reset_mid();
`ifdef TIMER_SCHED_PERIODIC_EN
      test_periodic();
`endif
      step(2);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: %0d events outstanding, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
